// File: rtl/tlb_ctrl.sv
// 16-entry MIPS-style TLB controller: TLBWI/TLBWR/TLBR/TLBP with a CP0 Random register.
// Optional build macro TLB_FAST_PROBE_EN selects a single-cycle parallel TLBP instead of the sequential scan.
module tlb_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  input  logic [3:0]    index,
  input  logic [3:0]    wired,
  input  logic [79:0]   entry_in,
  input  logic [7:0]    probe_asid,
  input  logic [18:0]   probe_vpn2,
  output logic          done,
  output logic [79:0]   rd_entry,
  output logic          probe_hit,
  output logic [3:0]    probe_index,
  output logic [3:0]    random,
  output logic [1279:0] tlb_entries
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_TLBWI = 2'd0;
  localparam logic [1:0] OP_TLBWR = 2'd1;
  localparam logic [1:0] OP_TLBR  = 2'd2;
  localparam logic [1:0] OP_TLBP  = 2'd3;

  state_t        state_r;
  state_t        state_next_s;
  logic [79:0]   entry_r [16];
  logic [79:0]   rd_entry_r;
  logic          probe_hit_r;
  logic [3:0]    probe_index_r;
  logic [3:0]    random_r;
  logic          done_r;
  logic          op_ready_r;
  logic [3:0]    scan_idx_r;
  logic [7:0]    probe_asid_r;
  logic [18:0]   probe_vpn2_r;
  logic          accept_s;
  logic          wr_en_s;
  logic [3:0]    wr_idx_s;
  logic          scan_match_s;

  // Global entries match on VPN2 alone; valid bits play no part in a probe.
  function automatic logic entry_match(input logic [79:0] ent,
                                       input logic [7:0]  asid,
                                       input logic [18:0] vpn2);
    return (ent[70:52] == vpn2) && ((ent[79:72] == asid) || ent[71]);
  endfunction

  assign accept_s     = (state_r == ST_IDLE) && op_valid;
  assign scan_match_s = entry_match(entry_r[scan_idx_r], probe_asid_r, probe_vpn2_r);

`ifdef TLB_FAST_PROBE_EN
  logic [15:0] fast_match_s;
  logic        fast_hit_s;
  logic [3:0]  fast_idx_s;

  // Parallel compare of all entries; scanning downward leaves the lowest match.
  always_comb begin
    fast_match_s = 16'd0;
    fast_idx_s   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      fast_match_s[i] = entry_match(entry_r[i], probe_asid, probe_vpn2);
      fast_idx_s      = fast_match_s[i] ? 4'(i) : fast_idx_s;
    end
    fast_hit_s = |fast_match_s;
  end
`endif

  // Write port decode: indexed or random-slot write on accept.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = 4'd0;
    if (accept_s && (op_code == OP_TLBWI)) begin
      wr_en_s  = 1'b1;
      wr_idx_s = index;
    end else if (accept_s && (op_code == OP_TLBWR)) begin
      wr_en_s  = 1'b1;
      wr_idx_s = random_r;
    end else begin
      wr_en_s  = 1'b0;
      wr_idx_s = 4'd0;
    end
  end

  // Next-state logic for the operation sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (op_valid) begin
          if (op_code == OP_TLBP) begin
`ifdef TLB_FAST_PROBE_EN
            state_next_s = ST_DONE;
`else
            state_next_s = ST_PROBE;
`endif
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PROBE: begin
        if (scan_match_s || (scan_idx_r == 4'd15)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_PROBE;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register with registered handshake/completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      done_r     <= 1'b0;
      op_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      done_r     <= (state_next_s == ST_DONE);
      op_ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Random register: free-running down-counter bounded below by Wired.
  always_ff @(posedge clk) begin
    if (rst) begin
      random_r <= 4'd15;
    end else if (random_r <= wired) begin
      random_r <= 4'd15;
    end else begin
      random_r <= random_r - 4'd1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        entry_r[i] <= 80'd0;
      end
    end else if (wr_en_s) begin
      entry_r[wr_idx_s] <= entry_in;
    end
  end

  // Read and probe result registers, plus the sequential scan pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_entry_r    <= 80'd0;
      probe_hit_r   <= 1'b0;
      probe_index_r <= 4'd0;
      scan_idx_r    <= 4'd0;
      probe_asid_r  <= 8'd0;
      probe_vpn2_r  <= 19'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_valid && (op_code == OP_TLBR)) begin
            rd_entry_r <= entry_r[index];
          end else if (op_valid && (op_code == OP_TLBP)) begin
`ifdef TLB_FAST_PROBE_EN
            probe_hit_r   <= fast_hit_s;
            probe_index_r <= fast_idx_s;
`else
            scan_idx_r    <= 4'd0;
            probe_asid_r  <= probe_asid;
            probe_vpn2_r  <= probe_vpn2;
`endif
          end
        end
        ST_PROBE: begin
          if (scan_match_s) begin
            probe_hit_r   <= 1'b1;
            probe_index_r <= scan_idx_r;
          end else if (scan_idx_r == 4'd15) begin
            probe_hit_r   <= 1'b0;
            probe_index_r <= 4'd0;
          end else begin
            scan_idx_r    <= scan_idx_r + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign tlb_entries[80*g +: 80] = entry_r[g];
  end

  assign op_ready    = op_ready_r;
  assign done        = done_r;
  assign rd_entry    = rd_entry_r;
  assign probe_hit   = probe_hit_r;
  assign probe_index = probe_index_r;
  assign random      = random_r;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed self-checking bench for tlb_ctrl; honours TLB_FAST_PROBE_EN for probe latencies.
module tb_tlb_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [1:0]    op_code;
  logic          op_ready;
  logic [3:0]    index;
  logic [3:0]    wired;
  logic [79:0]   entry_in;
  logic [7:0]    probe_asid;
  logic [18:0]   probe_vpn2;
  logic          done;
  logic [79:0]   rd_entry;
  logic          probe_hit;
  logic [3:0]    probe_index;
  logic [3:0]    random;
  logic [1279:0] tlb_entries;

  int n_pass  = 0;
  int n_total = 0;

`ifdef TLB_FAST_PROBE_EN
  localparam int LAT_P5   = 1;
  localparam int LAT_P3   = 1;
  localparam int LAT_MISS = 1;
`else
  localparam int LAT_P5   = 7;
  localparam int LAT_P3   = 5;
  localparam int LAT_MISS = 17;
`endif

  localparam logic [79:0] E_WR = {8'h22, 1'b0, 19'h00001, 24'h000013, 1'b1, 1'b1, 24'h000031, 1'b1, 1'b1};
  localparam logic [79:0] E5   = {8'hAB, 1'b0, 19'h12345, 24'hABCDEF, 1'b1, 1'b1, 24'h123456, 1'b0, 1'b1};
  localparam logic [79:0] E3G  = {8'h01, 1'b1, 19'h00777, 24'h000333, 1'b0, 1'b1, 24'h000444, 1'b0, 1'b1};
  localparam logic [79:0] E3N  = {8'h01, 1'b0, 19'h00777, 24'h000333, 1'b0, 1'b1, 24'h000444, 1'b0, 1'b1};

  tlb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_ready   (op_ready),
    .index      (index),
    .wired      (wired),
    .entry_in   (entry_in),
    .probe_asid (probe_asid),
    .probe_vpn2 (probe_vpn2),
    .done       (done),
    .rd_entry   (rd_entry),
    .probe_hit  (probe_hit),
    .probe_index(probe_index),
    .random     (random),
    .tlb_entries(tlb_entries)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [1279:0] obs, input logic [1279:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and count cycles until done (1 = done in T+1).
  task automatic do_op(input logic [1:0] code, input logic [3:0] idx, input logic [79:0] ent,
                       input logic [7:0] asid, input logic [18:0] vpn2, output int lat);
    op_code    = code;
    index      = idx;
    entry_in   = ent;
    probe_asid = asid;
    probe_vpn2 = vpn2;
    op_valid   = 1'b1;
    step();
    op_valid   = 1'b0;
    lat        = 1;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          n_done;
    int          guard;
    logic [3:0]  exp_seq [5];
    logic [1279:0] exp_tlb;

    rst = 1'b1; op_valid = 1'b0; op_code = 2'd0; index = 4'd0; wired = 4'd12;
    entry_in = 80'd0; probe_asid = 8'd0; probe_vpn2 = 19'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_op_ready", op_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_entries", tlb_entries, 0);
    chk("rst_rd_entry", rd_entry, 0);
    chk("rst_probe_hit", probe_hit, 0);

    // Wired=12: 15,14,13,12 then reload to 15.
    exp_seq[0] = 4'd15; exp_seq[1] = 4'd14; exp_seq[2] = 4'd13; exp_seq[3] = 4'd12; exp_seq[4] = 4'd15;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("random_seq%0d", i), random, exp_seq[i]);
      step();
    end

    guard = 0;
    while (random !== 4'd13 && guard < 20) begin
      step();
      guard++;
    end
    chk("random_is_13", random, 13);
    do_op(2'd1, 4'd0, E_WR, 8'd0, 19'd0, lat);
    chk("lat_wr", lat, 1);
    step();
    exp_tlb = '0;
    exp_tlb[13*80 +: 80] = E_WR;
    chk("wr_entry13_only", tlb_entries, exp_tlb);
    wired = 4'd0;

    do_op(2'd0, 4'd5, E5, 8'd0, 19'd0, lat);
    chk("lat_wi5", lat, 1);
    step();
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", op_ready, 1);
    chk("tlb_slot5", tlb_entries[479:400], E5);

    do_op(2'd2, 4'd5, 80'd0, 8'd0, 19'd0, lat);
    chk("lat_r5", lat, 1);
    chk("rd_entry5", rd_entry, E5);
    step();

    do_op(2'd3, 4'd0, 80'd0, 8'hAB, 19'h12345, lat);
    chk("lat_p5", lat, LAT_P5);
    chk("p5_hit", probe_hit, 1);
    chk("p5_index", probe_index, 5);
    step();

    do_op(2'd0, 4'd3, E3G, 8'd0, 19'd0, lat);
    step();
    do_op(2'd3, 4'd0, 80'd0, 8'h55, 19'h00777, lat);
    chk("lat_p3_global", lat, LAT_P3);
    chk("p3_hit", probe_hit, 1);
    chk("p3_index", probe_index, 3);
    step();

    do_op(2'd0, 4'd3, E3N, 8'd0, 19'd0, lat);
    step();
    chk("probe_hit_holds", probe_hit, 1);
    chk("probe_index_holds", probe_index, 3);
    chk("rd_entry_holds", rd_entry, E5);
    do_op(2'd3, 4'd0, 80'd0, 8'h55, 19'h00777, lat);
    chk("lat_miss", lat, LAT_MISS);
    chk("miss_hit", probe_hit, 0);
    chk("miss_index", probe_index, 0);
    step();

    // Reset while the sequential scan sits on index 7 (cycle T+8).
    op_code = 2'd3; probe_asid = 8'h00; probe_vpn2 = 19'h7FFFF; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    chk("busy_not_ready", op_ready, 0);
    n_done = 0;
    repeat (7) begin
      step();
      if (done === 1'b1) n_done++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_op_ready", op_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_entries", tlb_entries, 0);
    chk("midrst_random", random, 15);
    chk("midrst_rd_entry", rd_entry, 0);
    repeat (20) begin
      step();
      if (done === 1'b1) n_done++;
    end
    chk("midrst_no_done", n_done, 0);

    wired = 4'd15;
    repeat (3) begin
      step();
      chk("wired15_random", random, 15);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
